// File: rtl/ram_byte_loader.sv
// ram_byte_loader
//   Write-side feeder for the message RAM. Collects a byte stream over a
//   valid/ready handshake, packs BPW bytes MSB-first into one msg_width-bit
//   word and writes the words to RAM addresses 0 .. mem_height-1 in order,
//   then reports completion. Every output is launched from posedge clk so it
//   is stable across the RAM's negedge write.
//
//   Build option: define CHECKSUM_EN to append one extra (unwritten) word to
//   every load that is compared against the running sum of all written words.
//   Without it load_err is tied low.
//
// Ports
//   clk         clock, all state changes on posedge
//   rst_n       asynchronous active-low reset
//   start       single-cycle pulse, begins a load (honoured in IDLE/DONE only)
//   byte_in     incoming byte
//   byte_valid  byte_in is valid this cycle
//   byte_ready  block accepts a byte this cycle (state decode only)
//   we          RAM write enable, one clock per word
//   w_addr      RAM write address
//   data_in     RAM write data, holds its last value between writes
//   load_busy   load in progress
//   load_done   all words written, sticky until the next start
//   load_err    checksum mismatch (CHECKSUM_EN builds only)
module ram_byte_loader #(
    parameter int msg_width  = 16,
    parameter int mem_height = 32,
    parameter int addr       = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [7:0]           byte_in,
    input  logic                 byte_valid,
    output logic                 byte_ready,
    output logic                 we,
    output logic [addr-1:0]      w_addr,
    output logic [msg_width-1:0] data_in,
    output logic                 load_busy,
    output logic                 load_done,
    output logic                 load_err
);

    localparam int BPW = msg_width / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CW-1:0]   LAST_BYTE = CW'(BPW - 1);
    localparam logic [addr-1:0] LAST_ADDR = addr'(mem_height - 1);

    typedef enum logic [2:0] {
        IDLE,
        ASSEMBLE,
        WRITE,
        CHECK,
        DONE
    } state_t;

    state_t                 state;
    logic [CW-1:0]          cnt;
    // Only the bytes already received for the current word are kept; the
    // incoming byte completes the word directly from byte_in.
    logic [msg_width-9:0]   shreg;
    logic [msg_width-1:0]   word_next;
    logic                   xfer;

`ifdef CHECKSUM_EN
    logic [msg_width-1:0]   csum;
    logic                   err_q;
    assign load_err = err_q;
`else
    assign load_err = 1'b0;
`endif

    assign byte_ready = (state == ASSEMBLE) || (state == CHECK);
    assign load_busy  = (state == ASSEMBLE) || (state == WRITE) || (state == CHECK);

    always_comb begin
        word_next = {shreg, byte_in};
        xfer      = byte_valid && byte_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            shreg     <= '0;
            we        <= 1'b0;
            w_addr    <= '0;
            data_in   <= '0;
            load_done <= 1'b0;
`ifdef CHECKSUM_EN
            csum      <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        w_addr    <= '0;
                        cnt       <= '0;
                        load_done <= 1'b0;
`ifdef CHECKSUM_EN
                        csum      <= '0;
                        err_q     <= 1'b0;
`endif
                        state     <= ASSEMBLE;
                    end
                end

                ASSEMBLE: begin
                    if (xfer) begin
                        shreg <= word_next[msg_width-9:0];
                        if (cnt == LAST_BYTE) begin
                            data_in <= word_next;
                            we      <= 1'b1;
                            cnt     <= '0;
`ifdef CHECKSUM_EN
                            csum    <= csum + word_next;
`endif
                            state   <= WRITE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

                WRITE: begin
                    we <= 1'b0;
                    if (w_addr == LAST_ADDR) begin
`ifdef CHECKSUM_EN
                        state     <= CHECK;
`else
                        load_done <= 1'b1;
                        state     <= DONE;
`endif
                    end else begin
                        w_addr <= w_addr + addr'(1);
                        state  <= ASSEMBLE;
                    end
                end

`ifdef CHECKSUM_EN
                // Trailing checksum word: assembled like data but never written.
                CHECK: begin
                    if (xfer) begin
                        shreg <= word_next[msg_width-9:0];
                        if (cnt == LAST_BYTE) begin
                            cnt       <= '0;
                            err_q     <= (word_next != csum);
                            load_done <= 1'b1;
                            state     <= DONE;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
`endif

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_byte_loader.sv
module tb_ram_byte_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    // main instance (defaults: 16-bit words, 32 words)
    logic        start, byte_valid, byte_ready, we, load_busy, load_done, load_err;
    logic [7:0]  byte_in;
    logic [4:0]  w_addr;
    logic [15:0] data_in;

    // small instance (mem_height = 3)
    logic        s_start, s_valid, s_ready, s_we, s_busy, s_done, s_err;
    logic [7:0]  s_byte;
    logic [4:0]  s_addr;
    logic [15:0] s_data;

    ram_byte_loader #(.msg_width(16), .mem_height(32), .addr(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .byte_in(byte_in),
        .byte_valid(byte_valid), .byte_ready(byte_ready), .we(we),
        .w_addr(w_addr), .data_in(data_in), .load_busy(load_busy),
        .load_done(load_done), .load_err(load_err)
    );

    ram_byte_loader #(.msg_width(16), .mem_height(3), .addr(5)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .byte_in(s_byte),
        .byte_valid(s_valid), .byte_ready(s_ready), .we(s_we),
        .w_addr(s_addr), .data_in(s_data), .load_busy(s_busy),
        .load_done(s_done), .load_err(s_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // RAM image captured at the negedge write, plus a running write count.
    logic [15:0] mem [32];
    int          we_count = 0;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            mem[w_addr] <= data_in;
            we_count    <= we_count + 1;
            chk("ready_low_in_write", {31'b0, byte_ready}, 32'd0);
        end
        if (s_we === 1'b1)
            chk("small_addr_in_range", {31'b0, (s_addr <= 5'd2)}, 32'd1);
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model helpers ----------------
    function automatic logic [15:0] model_word(input logic [7:0] q[$], input int i);
        return {q[2*i], q[2*i+1]};
    endfunction

    function automatic logic [15:0] model_sum(input logic [7:0] q[$]);
        logic [15:0] s = '0;
        for (int i = 0; i < 32; i++) s = s + model_word(q, i);
        return s;
    endfunction

    task automatic check_load(input logic [7:0] q[$], input string tag);
        for (int i = 0; i < 32; i++)
            chk($sformatf("%s_word%0d", tag, i), {16'b0, mem[i]}, {16'b0, model_word(q, i)});
    endtask

    // ---------------- stimulus helpers (main instance) ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] b, input int unsigned gap);
        int guard = 0;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_in    = b;
        while (byte_ready !== 1'b1) begin
            if (guard == 40) begin
                chk("feed_timeout", 32'd0, 32'd1);
                break;
            end
            guard++;
            @(negedge clk);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] q[$], input int unsigned max_gap);
        foreach (q[i]) feed(q[i], (max_gap == 0) ? 0 : $urandom_range(max_gap, 0));
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (load_done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("load_done", {31'b0, load_done}, 32'd1);
    endtask

    task automatic finish_load(input logic [7:0] q[$]);
`ifdef CHECKSUM_EN
        logic [15:0] s = model_sum(q);
        feed(s[15:8], 0);
        feed(s[7:0], 0);
`endif
        wait_done(20);
        chk("load_err_clean", {31'b0, load_err}, 32'd0);
    endtask

    task automatic do_reset();
        start = 0; byte_valid = 0; byte_in = 0;
        s_start = 0; s_valid = 0; s_byte = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_we", {31'b0, we}, 0);
        chk("rst_addr", {27'b0, w_addr}, 0);
        chk("rst_data", {16'b0, data_in}, 0);
        chk("rst_ready", {31'b0, byte_ready}, 0);
        chk("rst_busy", {31'b0, load_busy}, 0);
        chk("rst_done", {31'b0, load_done}, 0);
        chk("rst_err", {31'b0, load_err}, 0);
        chk("rst_s_ready", {31'b0, s_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- vector table for the mem_height=3 instance ----------------
    typedef struct {
        logic        st;
        logic        v;
        logic [7:0]  b;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [15:0] e_data;
        logic        e_rdy;
        logic        e_busy;
        logic        e_done;
        logic        e_err;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic v, input logic [7:0] b,
                                input logic e_we, input logic [4:0] e_addr,
                                input logic [15:0] e_data, input logic e_rdy,
                                input logic e_busy, input logic e_done);
        vec_t r;
        r = '{st, v, b, e_we, e_addr, e_data, e_rdy, e_busy, e_done, 1'b0};
        return r;
    endfunction

    vec_t        vecs[$];
    logic [7:0]  ramp[$];
    logic [7:0]  rq[$];
    int          base;

    initial begin
        rst_n = 1'b1;
        start = 0; byte_valid = 0; byte_in = 0;
        s_start = 0; s_valid = 0; s_byte = 0;
        for (int i = 0; i < 64; i++) ramp.push_back(8'(i));
        #2;
        do_reset();

        // ---- table: mem_height = 3, including ignored starts in WRITE/ASSEMBLE ----
        //           st v  byte   we addr data      rdy busy done
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 16'h0000, 1, 1, 0));
        vecs.push_back(mk(0, 1, 8'h11, 0, 0, 16'h0000, 1, 1, 0));
        vecs.push_back(mk(0, 1, 8'h22, 1, 0, 16'h1122, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'h33, 0, 1, 16'h1122, 1, 1, 0));
        vecs.push_back(mk(0, 1, 8'h33, 0, 1, 16'h1122, 1, 1, 0));
        vecs.push_back(mk(0, 1, 8'h44, 1, 1, 16'h3344, 0, 1, 0));
        vecs.push_back(mk(1, 0, 8'h00, 0, 2, 16'h3344, 1, 1, 0));
        vecs.push_back(mk(0, 1, 8'h55, 0, 2, 16'h3344, 1, 1, 0));
        vecs.push_back(mk(1, 1, 8'h66, 1, 2, 16'h5566, 0, 1, 0));
`ifdef CHECKSUM_EN
        vecs.push_back(mk(0, 0, 8'h00, 0, 2, 16'h5566, 1, 1, 0));
        vecs.push_back(mk(0, 1, 8'h99, 0, 2, 16'h5566, 1, 1, 0));
        vecs.push_back(mk(0, 1, 8'hCC, 0, 2, 16'h5566, 0, 0, 1));
`else
        vecs.push_back(mk(0, 0, 8'h00, 0, 2, 16'h5566, 0, 0, 1));
`endif
        vecs.push_back(mk(0, 1, 8'h77, 0, 2, 16'h5566, 0, 0, 1));
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 16'h5566, 1, 1, 0));

        foreach (vecs[i]) begin
            s_start = vecs[i].st;
            s_valid = vecs[i].v;
            s_byte  = vecs[i].b;
            @(negedge clk);
            chk($sformatf("vec%0d_we", i),   {31'b0, s_we},    {31'b0, vecs[i].e_we});
            chk($sformatf("vec%0d_addr", i), {27'b0, s_addr},  {27'b0, vecs[i].e_addr});
            chk($sformatf("vec%0d_data", i), {16'b0, s_data},  {16'b0, vecs[i].e_data});
            chk($sformatf("vec%0d_rdy", i),  {31'b0, s_ready}, {31'b0, vecs[i].e_rdy});
            chk($sformatf("vec%0d_busy", i), {31'b0, s_busy},  {31'b0, vecs[i].e_busy});
            chk($sformatf("vec%0d_done", i), {31'b0, s_done},  {31'b0, vecs[i].e_done});
            chk($sformatf("vec%0d_err", i),  {31'b0, s_err},   {31'b0, vecs[i].e_err});
        end
        s_start = 0; s_valid = 0;

        // ---- continuous ramp 0x00..0x3F ----
        base = we_count;
        pulse_start();
        chk("t1_busy", {31'b0, load_busy}, 1);
        chk("t1_ready", {31'b0, byte_ready}, 1);
        send_stream(ramp, 0);
        chk("t1_last_we", {31'b0, we}, 1);
        chk("t1_last_addr", {27'b0, w_addr}, 31);
        @(negedge clk);
`ifdef CHECKSUM_EN
        chk("t1_check_done", {31'b0, load_done}, 0);
        chk("t1_check_ready", {31'b0, byte_ready}, 1);
        chk("t1_check_we", {31'b0, we}, 0);
        begin
            logic [15:0] s;
            s = model_sum(ramp);
            chk("t1_model_sum", {16'b0, s}, 32'hE400);
            feed(s[15:8], 0);
            feed(s[7:0], 0);
        end
        chk("t1_err", {31'b0, load_err}, 0);
`endif
        chk("t1_done", {31'b0, load_done}, 1);
        chk("t1_we_low", {31'b0, we}, 0);
        chk("t1_ready_low", {31'b0, byte_ready}, 0);
        repeat (3) @(negedge clk);
        chk("t1_done_sticky", {31'b0, load_done}, 1);
        chk("t1_ready_stays_low", {31'b0, byte_ready}, 0);
        chk("t1_hold_addr", {27'b0, w_addr}, 31);
        chk("t1_we_count", we_count - base, 32);
        chk("t1_addr0", {16'b0, mem[0]}, 32'h0001);
        chk("t1_addr1", {16'b0, mem[1]}, 32'h0203);
        chk("t1_addr31", {16'b0, mem[31]}, 32'h3E3F);
        check_load(ramp, "t1");

        // ---- same stream, random valid gaps 0..5 ----
        base = we_count;
        pulse_start();
        send_stream(ramp, 5);
        finish_load(ramp);
        repeat (2) @(negedge clk);
        chk("t2_we_count", we_count - base, 32);
        check_load(ramp, "t2");

        // ---- start pulses in ASSEMBLE and WRITE are ignored ----
        base = we_count;
        pulse_start();
        feed(ramp[0], 0);
        pulse_start();
        chk("t3_asm_addr", {27'b0, w_addr}, 0);
        chk("t3_asm_busy", {31'b0, load_busy}, 1);
        feed(ramp[1], 0);
        chk("t3_write_we", {31'b0, we}, 1);
        pulse_start();
        chk("t3_after_write_addr", {27'b0, w_addr}, 1);
        chk("t3_after_write_busy", {31'b0, load_busy}, 1);
        for (int i = 2; i < 64; i++) feed(ramp[i], 0);
        finish_load(ramp);
        repeat (2) @(negedge clk);
        chk("t3_we_count", we_count - base, 32);
        check_load(ramp, "t3");
        pulse_start();
        chk("t3_restart_done", {31'b0, load_done}, 0);
        chk("t3_restart_addr", {27'b0, w_addr}, 0);
        chk("t3_restart_busy", {31'b0, load_busy}, 1);

        // ---- reset mid-load after 5 bytes ----
        for (int i = 0; i < 5; i++) feed(8'h10 + 8'(i), 0);
        rst_n = 1'b0;
        #1;
        chk("t4_we", {31'b0, we}, 0);
        chk("t4_addr", {27'b0, w_addr}, 0);
        chk("t4_data", {16'b0, data_in}, 0);
        chk("t4_ready", {31'b0, byte_ready}, 0);
        chk("t4_busy", {31'b0, load_busy}, 0);
        chk("t4_done", {31'b0, load_done}, 0);
        chk("t4_err", {31'b0, load_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        base = we_count;
        pulse_start();
        feed(8'hAA, 0);
        feed(8'hBB, 0);
        chk("t4_we_after", {31'b0, we}, 1);
        chk("t4_addr_after", {27'b0, w_addr}, 0);
        @(negedge clk);
        chk("t4_mem0", {16'b0, mem[0]}, 32'hAABB);
        chk("t4_we_count", we_count - base, 1);

        // ---- random bytes with random gaps ----
        do_reset();
        for (int i = 0; i < 64; i++) rq.push_back(8'($urandom));
        base = we_count;
        pulse_start();
        send_stream(rq, 3);
        finish_load(rq);
        repeat (2) @(negedge clk);
        chk("t5_we_count", we_count - base, 32);
        check_load(rq, "t5");

`ifdef CHECKSUM_EN
        // ---- wrong checksum word sets load_err, no extra write ----
        base = we_count;
        pulse_start();
        send_stream(ramp, 0);
        begin
            logic [15:0] s;
            s = model_sum(ramp) + 16'd1;
            feed(s[15:8], 0);
            feed(s[7:0], 0);
        end
        wait_done(20);
        chk("t6_err", {31'b0, load_err}, 1);
        repeat (2) @(negedge clk);
        chk("t6_err_sticky", {31'b0, load_err}, 1);
        chk("t6_we_count", we_count - base, 32);
        pulse_start();
        chk("t6_err_cleared", {31'b0, load_err}, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
